// File: rtl/integer_execute_pkg.sv
// Shared types for the integer execute stage: issue-buffer payload, ROB completion
// record and funct3 encodings.
package integer_execute_pkg;

  localparam int ROB_ID_WIDTH = 6;
  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Instructions with none of the type flags set are I-type ALU ops.
  typedef struct packed {
    logic        entry_valid;
    rob_id_t     rob_id;
    logic [31:0] pc;
    logic [31:0] src1_data;
    logic [31:0] src2_data;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        is_r_type;
    logic        is_u_type;
    logic        is_lui;
    logic        is_b_type;
    logic        is_jal;
    logic        is_jalr;
    logic        is_sub;
    logic        is_sra_srai;
    logic        br_dir_pred;
  } iiq_issue_data_t;

  localparam int IIQ_ISSUE_DATA_WIDTH = $bits(iiq_issue_data_t);

  typedef struct packed {
    logic        valid;
    rob_id_t     rob_id;
    logic [31:0] reg_data;
    logic        br_mispred;
  } rob_int_wb_t;

endpackage

// File: rtl/integer_execute_int_alu.sv
// Combinational integer ALU: arithmetic/logic/shift/compare ops, lui/auipc and the
// pc+4 link value. Branches produce 0.
module int_alu
  import integer_execute_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_pc,
  input  logic        i_is_r_type,
  input  logic        i_is_u_type,
  input  logic        i_is_lui,
  input  logic        i_is_b_type,
  input  logic        i_is_link,
  input  logic        i_is_sub,
  input  logic        i_is_sra,
  output logic [31:0] o_result
);

  logic [31:0] w_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_sra;
  logic [31:0] w_alu;

  assign w_b     = i_is_r_type ? i_src2 : i_imm;
  assign w_shamt = w_b[4:0];
  assign w_sra   = $signed(i_src1) >>> w_shamt;

  always_comb begin
    w_alu = 32'd0;
    case (i_funct3)
      F3_ADD_SUB: w_alu = (i_is_sub && i_is_r_type) ? (i_src1 - w_b) : (i_src1 + w_b);
      F3_SLL:     w_alu = i_src1 << w_shamt;
      F3_SLT:     w_alu = {31'd0, $signed(i_src1) < $signed(w_b)};
      F3_SLTU:    w_alu = {31'd0, i_src1 < w_b};
      F3_XOR:     w_alu = i_src1 ^ w_b;
      F3_SRL_SRA: w_alu = i_is_sra ? w_sra : (i_src1 >> w_shamt);
      F3_OR:      w_alu = i_src1 | w_b;
      F3_AND:     w_alu = i_src1 & w_b;
      default:    w_alu = 32'd0;
    endcase
  end

  always_comb begin
    o_result = w_alu;
    if (i_is_b_type)      o_result = 32'd0;
    else if (i_is_link)   o_result = i_pc + 32'd4;
    else if (i_is_u_type) o_result = i_is_lui ? i_imm : (i_pc + i_imm);
  end

endmodule

// File: rtl/integer_execute.sv
// Integer execute stage: same-cycle result broadcast, registered ROB completion,
// one-cycle fetch redirect on mispredict and a saturating mispredict counter.
module integer_execute
  import integer_execute_pkg::*;
#(
  parameter int MISPRED_CTR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_aL,
  input  logic                         init,
  input  iiq_issue_data_t              issue_data,
  output logic                         alu_broadcast_valid,
  output rob_id_t                      alu_broadcast_rob_id,
  output logic [31:0]                  alu_broadcast_reg_data,
  output logic                         rob_wb_valid,
  output rob_id_t                      rob_wb_rob_id,
  output logic [31:0]                  rob_wb_reg_data,
  output logic                         rob_wb_br_mispred,
  output logic                         fetch_redirect_valid,
  output logic [31:0]                  fetch_redirect_pc,
  output logic [MISPRED_CTR_WIDTH-1:0] mispred_count
);

  logic        w_live;
  logic [31:0] w_result;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_target;
  logic [31:0] w_redirect_pc;
  logic        w_br_cond;
  logic        w_taken;
  logic        w_mispred;

  rob_int_wb_t                  r_wb;
  logic                         r_redirect_valid;
  logic [31:0]                  r_redirect_pc;
  logic [MISPRED_CTR_WIDTH-1:0] r_mispred_count;

  int_alu u_alu (
    .i_funct3    (issue_data.funct3),
    .i_src1      (issue_data.src1_data),
    .i_src2      (issue_data.src2_data),
    .i_imm       (issue_data.imm),
    .i_pc        (issue_data.pc),
    .i_is_r_type (issue_data.is_r_type),
    .i_is_u_type (issue_data.is_u_type),
    .i_is_lui    (issue_data.is_lui),
    .i_is_b_type (issue_data.is_b_type),
    .i_is_link   (issue_data.is_jal | issue_data.is_jalr),
    .i_is_sub    (issue_data.is_sub),
    .i_is_sra    (issue_data.is_sra_srai),
    .o_result    (w_result)
  );

  // The instruction behind a redirecting branch is on the wrong path.
  assign w_live = issue_data.entry_valid & ~r_redirect_valid;

  always_comb begin
    w_br_cond = 1'b0;
    case (issue_data.funct3)
      F3_BEQ:  w_br_cond = issue_data.src1_data == issue_data.src2_data;
      F3_BNE:  w_br_cond = issue_data.src1_data != issue_data.src2_data;
      F3_BLT:  w_br_cond = $signed(issue_data.src1_data) < $signed(issue_data.src2_data);
      F3_BGE:  w_br_cond = $signed(issue_data.src1_data) >= $signed(issue_data.src2_data);
      F3_BLTU: w_br_cond = issue_data.src1_data < issue_data.src2_data;
      F3_BGEU: w_br_cond = issue_data.src1_data >= issue_data.src2_data;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_pc_plus4    = issue_data.pc + 32'd4;
  assign w_jalr_sum    = issue_data.src1_data + issue_data.imm;
  assign w_target      = issue_data.is_jalr ? {w_jalr_sum[31:1], 1'b0}
                                            : (issue_data.pc + issue_data.imm);
  assign w_taken       = issue_data.is_b_type ? w_br_cond
                                              : (issue_data.is_jal | issue_data.is_jalr);
  // jal is resolved by fetch; jalr is never predicted, so it always redirects.
  assign w_mispred     = issue_data.is_b_type ? (w_br_cond != issue_data.br_dir_pred)
                                              : issue_data.is_jalr;
  assign w_redirect_pc = w_taken ? w_target : w_pc_plus4;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_wb             <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_mispred_count  <= '0;
    end else if (init) begin
      r_wb             <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_mispred_count  <= '0;
    end else begin
      r_wb.valid       <= w_live;
      r_wb.rob_id      <= issue_data.rob_id;
      r_wb.reg_data    <= w_result;
      r_wb.br_mispred  <= w_mispred;
      r_redirect_valid <= w_live & w_mispred;
      r_redirect_pc    <= w_redirect_pc;
      if (w_live && w_mispred && (r_mispred_count != '1))
        r_mispred_count <= r_mispred_count + 1'b1;
    end
  end

  assign alu_broadcast_valid    = w_live;
  assign alu_broadcast_rob_id   = issue_data.rob_id;
  assign alu_broadcast_reg_data = w_result;
  assign rob_wb_valid           = r_wb.valid;
  assign rob_wb_rob_id          = r_wb.rob_id;
  assign rob_wb_reg_data        = r_wb.reg_data;
  assign rob_wb_br_mispred      = r_wb.br_mispred;
  assign fetch_redirect_valid   = r_redirect_valid;
  assign fetch_redirect_pc      = r_redirect_pc;
  assign mispred_count          = r_mispred_count;

endmodule

// File: tb/tb_integer_execute.sv
// Directed bench for integer_execute: ALU ops, branch resolution, redirect/squash,
// reset/init clearing and counter saturation (4-bit counter instance).
module tb_integer_execute;
  import integer_execute_pkg::*;

  logic            clk = 1'b0;
  logic            rst_aL = 1'b0;
  logic            init = 1'b0;
  iiq_issue_data_t issue_data = '0;
  logic            alu_broadcast_valid;
  rob_id_t         alu_broadcast_rob_id;
  logic [31:0]     alu_broadcast_reg_data;
  logic            rob_wb_valid;
  rob_id_t         rob_wb_rob_id;
  logic [31:0]     rob_wb_reg_data;
  logic            rob_wb_br_mispred;
  logic            fetch_redirect_valid;
  logic [31:0]     fetch_redirect_pc;
  logic [3:0]      mispred_count;

  int n_checks = 0;
  int n_fail   = 0;

  integer_execute #(.MISPRED_CTR_WIDTH(4)) dut (
    .clk                    (clk),
    .rst_aL                 (rst_aL),
    .init                   (init),
    .issue_data             (issue_data),
    .alu_broadcast_valid    (alu_broadcast_valid),
    .alu_broadcast_rob_id   (alu_broadcast_rob_id),
    .alu_broadcast_reg_data (alu_broadcast_reg_data),
    .rob_wb_valid           (rob_wb_valid),
    .rob_wb_rob_id          (rob_wb_rob_id),
    .rob_wb_reg_data        (rob_wb_reg_data),
    .rob_wb_br_mispred      (rob_wb_br_mispred),
    .fetch_redirect_valid   (fetch_redirect_valid),
    .fetch_redirect_pc      (fetch_redirect_pc),
    .mispred_count          (mispred_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // instruction builders
  function automatic iiq_issue_data_t mk_alu(input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] b, input logic r, input logic sub, input logic sra, input rob_id_t id);
    iiq_issue_data_t d = '0;
    d.entry_valid = 1'b1; d.rob_id = id; d.funct3 = f3; d.src1_data = a;
    d.is_r_type = r; d.is_sub = sub; d.is_sra_srai = sra; d.pc = 32'h1000;
    if (r) d.src2_data = b; else d.imm = b;
    return d;
  endfunction

  function automatic iiq_issue_data_t mk_br(input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm, input logic pred,
      input rob_id_t id);
    iiq_issue_data_t d = '0;
    d.entry_valid = 1'b1; d.rob_id = id; d.funct3 = f3; d.src1_data = a; d.src2_data = b;
    d.pc = pc; d.imm = imm; d.is_b_type = 1'b1; d.br_dir_pred = pred;
    return d;
  endfunction

  function automatic iiq_issue_data_t mk_u(input logic lui, input logic [31:0] imm,
      input logic [31:0] pc, input rob_id_t id);
    iiq_issue_data_t d = '0;
    d.entry_valid = 1'b1; d.rob_id = id; d.is_u_type = 1'b1; d.is_lui = lui;
    d.imm = imm; d.pc = pc;
    return d;
  endfunction

  // driver tasks
  task automatic drive(input iiq_issue_data_t d);
    @(negedge clk);
    issue_data = d;
  endtask

  task automatic idle_cycle();
    drive('0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_aL = 1'b0; init = 1'b0; issue_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rob_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b exp 0", rob_wb_valid); end
    n_checks++; if (rob_wb_reg_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data: got %h exp 0", rob_wb_reg_data); end
    n_checks++; if (fetch_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b exp 0", fetch_redirect_valid); end
    n_checks++; if (fetch_redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h exp 0", fetch_redirect_pc); end
    n_checks++; if (mispred_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", mispred_count); end
    @(negedge clk);
    rst_aL = 1'b1;
  endtask

  task automatic test_add();
    drive(mk_alu(F3_ADD_SUB, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 6'd3));
    #1;
    n_checks++; if (alu_broadcast_valid !== 1'b1) begin n_fail++; $display("FAIL add_bc_valid: got %b exp 1", alu_broadcast_valid); end
    n_checks++; if (alu_broadcast_reg_data !== 32'd12) begin n_fail++; $display("FAIL add_bc_data: got %h exp 0000000c", alu_broadcast_reg_data); end
    n_checks++; if (alu_broadcast_rob_id !== 6'd3) begin n_fail++; $display("FAIL add_bc_id: got %0d exp 3", alu_broadcast_rob_id); end
    @(posedge clk); #1;
    n_checks++; if (rob_wb_valid !== 1'b1) begin n_fail++; $display("FAIL add_wb_valid: got %b exp 1", rob_wb_valid); end
    n_checks++; if (rob_wb_reg_data !== 32'd12) begin n_fail++; $display("FAIL add_wb_data: got %h exp 0000000c", rob_wb_reg_data); end
    n_checks++; if (rob_wb_rob_id !== 6'd3) begin n_fail++; $display("FAIL add_wb_id: got %0d exp 3", rob_wb_rob_id); end
    n_checks++; if (rob_wb_br_mispred !== 1'b0) begin n_fail++; $display("FAIL add_wb_mispred: got %b exp 0", rob_wb_br_mispred); end
    n_checks++; if (fetch_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL add_redirect: got %b exp 0", fetch_redirect_valid); end
    idle_cycle();
    n_checks++; if (rob_wb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_wb_valid: got %b exp 0", rob_wb_valid); end
  endtask

  task automatic test_shifts();
    drive(mk_alu(F3_SRL_SRA, 32'h8000_0000, 32'h0000_0404, 1'b0, 1'b0, 1'b1, 6'd4));
    #1;
    n_checks++; if (alu_broadcast_reg_data !== 32'hF800_0000) begin n_fail++; $display("FAIL srai_data: got %h exp f8000000", alu_broadcast_reg_data); end
    drive(mk_alu(F3_SRL_SRA, 32'h8000_0000, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 6'd5));
    #1;
    n_checks++; if (alu_broadcast_reg_data !== 32'h0800_0000) begin n_fail++; $display("FAIL srli_data: got %h exp 08000000", alu_broadcast_reg_data); end
    @(posedge clk); #1;
    n_checks++; if (rob_wb_reg_data !== 32'h0800_0000) begin n_fail++; $display("FAIL srli_wb_data: got %h exp 08000000", rob_wb_reg_data); end
    idle_cycle();
  endtask

  // back-to-back issue of mixed ALU ops, one per cycle
  task automatic test_alu_table();
    iiq_issue_data_t v[13];
    logic [31:0]     e[13];
    iiq_issue_data_t jal_op;
    jal_op = '0; jal_op.entry_valid = 1'b1; jal_op.is_jal = 1'b1; jal_op.pc = 32'h80;
    jal_op.imm = 32'h100; jal_op.rob_id = 6'd22;
    v[0]  = mk_alu(F3_ADD_SUB, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 6'd10);          e[0]  = 32'hFFFF_FFFE;
    v[1]  = mk_alu(F3_SLL, 32'd1, 32'h3F, 1'b1, 1'b0, 1'b0, 6'd11);             e[1]  = 32'h8000_0000;
    v[2]  = mk_alu(F3_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 6'd12);      e[2]  = 32'd1;
    v[3]  = mk_alu(F3_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 6'd13);     e[3]  = 32'd0;
    v[4]  = mk_alu(F3_XOR, 32'hF0F0, 32'hFF00, 1'b0, 1'b0, 1'b0, 6'd14);        e[4]  = 32'h0FF0;
    v[5]  = mk_alu(F3_OR, 32'hF0F0, 32'h0F0F, 1'b1, 1'b0, 1'b0, 6'd15);         e[5]  = 32'hFFFF;
    v[6]  = mk_alu(F3_AND, 32'hF0F0, 32'hFF00, 1'b1, 1'b0, 1'b0, 6'd16);        e[6]  = 32'hF000;
    v[7]  = mk_alu(F3_ADD_SUB, 32'd10, 32'd3, 1'b0, 1'b1, 1'b0, 6'd17);         e[7]  = 32'd13;
    v[8]  = mk_u(1'b1, 32'h1234_5000, 32'h500, 6'd18);                          e[8]  = 32'h1234_5000;
    v[9]  = mk_u(1'b0, 32'h2000, 32'h1000, 6'd19);                              e[9]  = 32'h3000;
    v[10] = mk_alu(F3_SLT, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 6'd20);      e[10] = 32'd0;
    v[11] = mk_alu(F3_ADD_SUB, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0, 6'd21);  e[11] = 32'd1;
    v[12] = jal_op;                                                             e[12] = 32'h84;
    for (int i = 0; i < 13; i++) begin
      drive(v[i]);
      #1;
      n_checks++; if (alu_broadcast_reg_data !== e[i]) begin n_fail++; $display("FAIL alu_bc[%0d]: got %h exp %h", i, alu_broadcast_reg_data, e[i]); end
      @(posedge clk); #1;
      n_checks++; if (rob_wb_reg_data !== e[i] || rob_wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb[%0d]: got %h/%b exp %h/1", i, rob_wb_reg_data, rob_wb_valid, e[i]); end
      n_checks++; if (fetch_redirect_valid !== 1'b0 || rob_wb_br_mispred !== 1'b0) begin n_fail++; $display("FAIL alu_noredirect[%0d]: got %b/%b exp 0/0", i, fetch_redirect_valid, rob_wb_br_mispred); end
    end
    idle_cycle();
  endtask

  task automatic test_blt();
    drive(mk_br(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 6'd7));
    #1;
    n_checks++; if (alu_broadcast_valid !== 1'b1 || alu_broadcast_reg_data !== 32'd0) begin n_fail++; $display("FAIL blt_bc: got %b/%h exp 1/00000000", alu_broadcast_valid, alu_broadcast_reg_data); end
    @(posedge clk); #1;
    n_checks++; if (fetch_redirect_valid !== 1'b1) begin n_fail++; $display("FAIL blt_redirect: got %b exp 1", fetch_redirect_valid); end
    n_checks++; if (fetch_redirect_pc !== 32'h120) begin n_fail++; $display("FAIL blt_redirect_pc: got %h exp 00000120", fetch_redirect_pc); end
    n_checks++; if (mispred_count !== 4'd1) begin n_fail++; $display("FAIL blt_count: got %0d exp 1", mispred_count); end
    n_checks++; if (rob_wb_br_mispred !== 1'b1 || rob_wb_rob_id !== 6'd7) begin n_fail++; $display("FAIL blt_wb: got %b/%0d exp 1/7", rob_wb_br_mispred, rob_wb_rob_id); end
    idle_cycle();
    n_checks++; if (fetch_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL blt_pulse: got %b exp 0", fetch_redirect_valid); end
  endtask

  // each branch separated by an idle cycle so none is squashed
  task automatic test_branch_conds();
    iiq_issue_data_t v[6];
    logic            m[6];
    logic [31:0]     p[6];
    int              exp_cnt = 1;
    v[0] = mk_br(F3_BEQ,  32'd3, 32'd3, 32'h300, 32'h40, 1'b1, 6'd30);           m[0] = 1'b0; p[0] = 32'h340;
    v[1] = mk_br(F3_BNE,  32'd3, 32'd3, 32'h300, 32'h40, 1'b0, 6'd31);           m[1] = 1'b0; p[1] = 32'h304;
    v[2] = mk_br(F3_BLT,  32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 6'd32);   m[2] = 1'b0; p[2] = 32'h340;
    v[3] = mk_br(F3_BGE,  32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 6'd33);   m[3] = 1'b1; p[3] = 32'h304;
    v[4] = mk_br(F3_BLTU, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h40, 1'b0, 6'd34);   m[4] = 1'b1; p[4] = 32'h340;
    v[5] = mk_br(F3_BGEU, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h40, 1'b0, 6'd35);   m[5] = 1'b0; p[5] = 32'h304;
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      @(posedge clk); #1;
      if (m[i]) exp_cnt++;
      n_checks++; if (fetch_redirect_valid !== m[i] || rob_wb_br_mispred !== m[i]) begin n_fail++; $display("FAIL br_mispred[%0d]: got %b/%b exp %b", i, fetch_redirect_valid, rob_wb_br_mispred, m[i]); end
      n_checks++; if (fetch_redirect_pc !== p[i]) begin n_fail++; $display("FAIL br_pc[%0d]: got %h exp %h", i, fetch_redirect_pc, p[i]); end
      n_checks++; if (mispred_count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL br_count[%0d]: got %0d exp %0d", i, mispred_count, exp_cnt); end
      idle_cycle();
    end
  endtask

  task automatic test_back_to_back();
    drive(mk_br(F3_BEQ, 32'd1, 32'd2, 32'h200, 32'h10, 1'b1, 6'd40));
    @(posedge clk); #1;
    n_checks++; if (fetch_redirect_valid !== 1'b1 || fetch_redirect_pc !== 32'h204) begin n_fail++; $display("FAIL b2b_redirect: got %b/%h exp 1/00000204", fetch_redirect_valid, fetch_redirect_pc); end
    n_checks++; if (mispred_count !== 4'd4) begin n_fail++; $display("FAIL b2b_count1: got %0d exp 4", mispred_count); end
    drive(mk_alu(F3_ADD_SUB, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 6'd41));
    #1;
    n_checks++; if (alu_broadcast_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_squash_bc: got %b exp 0", alu_broadcast_valid); end
    @(posedge clk); #1;
    n_checks++; if (rob_wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_squash_wb: got %b exp 0", rob_wb_valid); end
    n_checks++; if (fetch_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse: got %b exp 0", fetch_redirect_valid); end
    idle_cycle();
    // two mispredicting branches back to back: only the first redirects
    drive(mk_br(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h80, 1'b0, 6'd42));
    drive(mk_br(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h700, 32'h80, 1'b0, 6'd43));
    #1;
    n_checks++; if (fetch_redirect_valid !== 1'b1 || fetch_redirect_pc !== 32'h680) begin n_fail++; $display("FAIL b2b_br_first: got %b/%h exp 1/00000680", fetch_redirect_valid, fetch_redirect_pc); end
    @(posedge clk); #1;
    n_checks++; if (fetch_redirect_valid !== 1'b0 || rob_wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_br_second: got %b/%b exp 0/0", fetch_redirect_valid, rob_wb_valid); end
    n_checks++; if (mispred_count !== 4'd5) begin n_fail++; $display("FAIL b2b_count2: got %0d exp 5", mispred_count); end
    idle_cycle();
  endtask

  task automatic test_jalr_reset();
    iiq_issue_data_t d = '0;
    d.entry_valid = 1'b1; d.is_jalr = 1'b1; d.src1_data = 32'h1001; d.imm = 32'd2;
    d.pc = 32'h40; d.rob_id = 6'd50;
    drive(d);
    #1;
    n_checks++; if (alu_broadcast_reg_data !== 32'h44) begin n_fail++; $display("FAIL jalr_bc: got %h exp 00000044", alu_broadcast_reg_data); end
    @(posedge clk); #1;
    n_checks++; if (fetch_redirect_valid !== 1'b1 || fetch_redirect_pc !== 32'h1002) begin n_fail++; $display("FAIL jalr_redirect: got %b/%h exp 1/00001002", fetch_redirect_valid, fetch_redirect_pc); end
    n_checks++; if (rob_wb_reg_data !== 32'h44 || rob_wb_br_mispred !== 1'b1) begin n_fail++; $display("FAIL jalr_wb: got %h/%b exp 00000044/1", rob_wb_reg_data, rob_wb_br_mispred); end
    n_checks++; if (mispred_count !== 4'd6) begin n_fail++; $display("FAIL jalr_count: got %0d exp 6", mispred_count); end
    issue_data = '0;
    #1 rst_aL = 1'b0;
    #1;
    n_checks++; if (fetch_redirect_valid !== 1'b0 || fetch_redirect_pc !== 32'd0) begin n_fail++; $display("FAIL rst_redirect: got %b/%h exp 0/00000000", fetch_redirect_valid, fetch_redirect_pc); end
    n_checks++; if (rob_wb_valid !== 1'b0 || rob_wb_reg_data !== 32'd0 || rob_wb_br_mispred !== 1'b0 || rob_wb_rob_id !== 6'd0) begin n_fail++; $display("FAIL rst_wb: got %b/%h/%b/%0d exp all 0", rob_wb_valid, rob_wb_reg_data, rob_wb_br_mispred, rob_wb_rob_id); end
    n_checks++; if (mispred_count !== 4'd0 || alu_broadcast_valid !== 1'b0) begin n_fail++; $display("FAIL rst_count_bc: got %0d/%b exp 0/0", mispred_count, alu_broadcast_valid); end
    @(negedge clk);
    rst_aL = 1'b1;
  endtask

  task automatic test_init();
    drive(mk_br(F3_BLTU, 32'd1, 32'd2, 32'h800, 32'h10, 1'b0, 6'd60));
    @(posedge clk); #1;
    n_checks++; if (fetch_redirect_valid !== 1'b1 || mispred_count !== 4'd1) begin n_fail++; $display("FAIL init_pre: got %b/%0d exp 1/1", fetch_redirect_valid, mispred_count); end
    @(negedge clk);
    issue_data = '0; init = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (fetch_redirect_valid !== 1'b0 || fetch_redirect_pc !== 32'd0 || mispred_count !== 4'd0) begin n_fail++; $display("FAIL init_clear: got %b/%h/%0d exp 0/0/0", fetch_redirect_valid, fetch_redirect_pc, mispred_count); end
    n_checks++; if (rob_wb_valid !== 1'b0 || rob_wb_reg_data !== 32'd0) begin n_fail++; $display("FAIL init_wb: got %b/%h exp 0/0", rob_wb_valid, rob_wb_reg_data); end
    drive(mk_alu(F3_ADD_SUB, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0, 6'd61));
    @(posedge clk); #1;
    n_checks++; if (rob_wb_valid !== 1'b0) begin n_fail++; $display("FAIL init_holds: got %b exp 0", rob_wb_valid); end
    @(negedge clk);
    init = 1'b0; issue_data = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 17; i++) begin
      drive(mk_br(F3_BNE, 32'd1, 32'd2, 32'h900, 32'h8, 1'b0, 6'(i)));
      @(posedge clk); #1;
      n_checks++; if (fetch_redirect_valid !== 1'b1) begin n_fail++; $display("FAIL sat_redirect[%0d]: got %b exp 1", i, fetch_redirect_valid); end
      idle_cycle();
    end
    n_checks++; if (mispred_count !== 4'hF) begin n_fail++; $display("FAIL sat_count: got %0d exp 15", mispred_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_shifts();
    test_alu_table();
    test_blt();
    test_branch_conds();
    test_back_to_back();
    test_jalr_reset();
    test_init();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
